// File: rtl/mmio_player_io.sv
// Memory-mapped I/O controller: region decode, exmem gating and a
// player-input register window with debounce, press flags and first latch.
module mmio_player_io #(
  parameter int          ADDR_W          = 16,
  parameter int          DATA_W          = 16,
  parameter int          NUM_PLAYERS     = 4,
  parameter int          KEY_W           = 8,
  parameter int unsigned DATA_BASE       = 16'hA000,
  parameter int unsigned IO_BASE         = 16'hC000,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_W-1:0]                adr,
  input  logic                             memread,
  input  logic                             memwrite,
  input  logic [DATA_W-1:0]                writedata,
  input  logic [NUM_PLAYERS*KEY_W-1:0]     player_raw,
  output logic                             mem_en,
  output logic [1:0]                       region,
  output logic [DATA_W-1:0]                io_rdata,
  output logic                             io_rvalid,
  output logic [NUM_PLAYERS-1:0]           player_flags,
  output logic                             first_valid,
  output logic [$clog2(NUM_PLAYERS)-1:0]   first_player,
  output logic                             irq
);

  localparam int PW = $clog2(NUM_PLAYERS);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NK = NUM_PLAYERS * KEY_W;
  localparam logic [ADDR_W-1:0] DBASE = ADDR_W'(DATA_BASE);
  localparam logic [ADDR_W-1:0] IBASE = ADDR_W'(IO_BASE);

  logic [NK-1:0]          sync1, sync2, stab, stab_nx;
  logic [CW-1:0]          cnt    [NUM_PLAYERS];
  logic [CW-1:0]          cnt_nx [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] press, clr_flags;
  logic                   is_io, is_data, wr_ctl, clr_first;
  logic [ADDR_W-1:0]      off;
  logic [DATA_W-1:0]      rd_mux, status;
  logic [PW-1:0]          low_idx;
  logic                   unused_wd;

  assign is_io   = adr >= IBASE;
  assign is_data = (adr >= DBASE) && !is_io;
  assign mem_en  = !is_io;
  assign off     = adr - IBASE;
  assign irq     = |player_flags;

  always_comb begin
    region = 2'd0;
    unique case (1'b1)
      is_io:   region = 2'd2;
      is_data: region = 2'd1;
      default: region = 2'd0;
    endcase
  end

  // Any differing cycle counts; stable only moves after an unbroken run.
  always_comb begin
    stab_nx = stab;
    press   = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      cnt_nx[i] = '0;
      if (sync2[i*KEY_W +: KEY_W] != stab[i*KEY_W +: KEY_W]) begin
        if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stab_nx[i*KEY_W +: KEY_W] = sync2[i*KEY_W +: KEY_W];
          press[i] = (stab[i*KEY_W +: KEY_W] == '0) &&
                     (sync2[i*KEY_W +: KEY_W] != '0);
        end else begin
          cnt_nx[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      if (press[i]) low_idx = PW'(i);
  end

  always_comb begin
    status = '0;
    status[DATA_W-1] = first_valid;
    status[DATA_W-4 +: PW] = first_player;
    status[NUM_PLAYERS-1:0] = player_flags;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (off == ADDR_W'(i))
        rd_mux = DATA_W'(stab[i*KEY_W +: KEY_W]);
    if (off == ADDR_W'(NUM_PLAYERS)) rd_mux = status;
  end

  assign wr_ctl    = memwrite && is_io &&
                     (off == ADDR_W'(NUM_PLAYERS + 1));
  assign clr_flags = wr_ctl ? writedata[NUM_PLAYERS-1:0] : '0;
  assign clr_first = wr_ctl && writedata[DATA_W-1];
  assign unused_wd = ^writedata[DATA_W-2:NUM_PLAYERS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1        <= '0;
      sync2        <= '0;
      stab         <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) cnt[i] <= '0;
      player_flags <= '0;
      first_valid  <= 1'b0;
      first_player <= '0;
      io_rdata     <= '0;
      io_rvalid    <= 1'b0;
    end else begin
      sync1 <= player_raw;
      sync2 <= sync1;
      stab  <= stab_nx;
      for (int i = 0; i < NUM_PLAYERS; i++) cnt[i] <= cnt_nx[i];
      player_flags <= (player_flags & ~clr_flags) | press;
      // A new press wins over a same-edge clear of the latch.
      if ((press != '0) && (!first_valid || clr_first)) begin
        first_valid  <= 1'b1;
        first_player <= low_idx;
      end else if (clr_first) begin
        first_valid  <= 1'b0;
        first_player <= '0;
      end
      io_rvalid <= memread && is_io;
      if (memread && is_io) io_rdata <= rd_mux;
    end
  end

endmodule
